// File: rtl/id_stage.sv
// RV32I decode stage: register file, decoder, load-use detection
// and the ID/EX pipeline register with stall/flush/bubble handling.
module id_stage #(
  parameter int          XLEN   = 32,
  parameter logic [31:0] NOP_IR = 32'h0000_0013
) (
  input  logic            iClk,
  input  logic            nRst,
  input  logic            iEn,
  input  logic            iStall,
  input  logic            iFlush,
  input  logic            iIF_Stall,
  input  logic [XLEN-1:0] iPC,
  input  logic [XLEN-1:0] iPC4,
  input  logic [XLEN-1:0] iIR,
  input  logic            iWB_En,
  input  logic [4:0]      iWB_Rd,
  input  logic [XLEN-1:0] iWB_Data,
  input  logic            iEX_MemRd,
  input  logic [4:0]      iEX_Rd,
  output logic            oStall,
  output logic            oValid,
  output logic [XLEN-1:0] oPC,
  output logic [XLEN-1:0] oPC4,
  output logic [XLEN-1:0] oIR,
  output logic [XLEN-1:0] oRS1D,
  output logic [XLEN-1:0] oRS2D,
  output logic [XLEN-1:0] oImm,
  output logic [4:0]      oRs1,
  output logic [4:0]      oRs2,
  output logic [4:0]      oRd,
  output logic [2:0]      oFunct3,
  output logic            oFunct7b5,
  output logic            oRegWr,
  output logic            oMemRd,
  output logic            oMemWr,
  output logic            oALUSrc,
  output logic            oBranch,
  output logic            oJal,
  output logic            oJalr,
  output logic            oLui,
  output logic            oAuipc,
  output logic            oIllegal
);

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc4;
    logic [XLEN-1:0] ir;
    logic [XLEN-1:0] rs1d;
    logic [XLEN-1:0] rs2d;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [2:0]      funct3;
    logic            f7b5;
    logic            regwr;
    logic            memrd;
    logic            memwr;
    logic            alusrc;
    logic            branch;
    logic            jal;
    logic            jalr;
    logic            lui;
    logic            auipc;
    logic            illegal;
  } id_ex_t;

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LD    = 7'b0000011;
  localparam logic [6:0] OP_ST    = 7'b0100011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_OP    = 7'b0110011;
  localparam logic [6:0] OP_MISC  = 7'b0001111;
  localparam logic [6:0] OP_SYS   = 7'b1110011;

  logic [XLEN-1:0] rf_q [32];

  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else if (iWB_En && iWB_Rd != 5'd0) begin
      rf_q[iWB_Rd] <= iWB_Data;
    end
  end

  logic [6:0]      opc;
  logic [4:0]      rs1, rs2, rd;
  logic [XLEN-1:0] rs1d, rs2d;
  logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opc = iIR[6:0];
  assign rs1 = iIR[19:15];
  assign rs2 = iIR[24:20];
  assign rd  = iIR[11:7];

  // Same-cycle writeback is visible to the reader.
  always_comb begin
    rs1d = rf_q[rs1];
    rs2d = rf_q[rs2];
    if (iWB_En && iWB_Rd != 5'd0 && iWB_Rd == rs1) rs1d = iWB_Data;
    if (iWB_En && iWB_Rd != 5'd0 && iWB_Rd == rs2) rs2d = iWB_Data;
    if (rs1 == 5'd0) rs1d = '0;
    if (rs2 == 5'd0) rs2d = '0;
  end

  assign imm_i = {{20{iIR[31]}}, iIR[31:20]};
  assign imm_s = {{20{iIR[31]}}, iIR[31:25], iIR[11:7]};
  assign imm_b = {{20{iIR[31]}}, iIR[7], iIR[30:25],
                  iIR[11:8], 1'b0};
  assign imm_u = {iIR[31:12], 12'b0};
  assign imm_j = {{12{iIR[31]}}, iIR[19:12], iIR[20],
                  iIR[30:21], 1'b0};

  id_ex_t dec, bub, ex_q, ex_d;
  logic   use1, use2, haz;

  always_comb begin
    dec        = '0;
    use1       = 1'b0;
    use2       = 1'b0;
    dec.valid  = 1'b1;
    dec.pc     = iPC;
    dec.pc4    = iPC4;
    dec.ir     = iIR;
    dec.rs1d   = rs1d;
    dec.rs2d   = rs2d;
    dec.rs1    = rs1;
    dec.rs2    = rs2;
    dec.rd     = rd;
    dec.funct3 = iIR[14:12];
    dec.f7b5   = iIR[30];
    unique case (opc)
      OP_LUI: begin
        dec.regwr = 1'b1; dec.alusrc = 1'b1;
        dec.lui = 1'b1; dec.imm = imm_u;
      end
      OP_AUIPC: begin
        dec.regwr = 1'b1; dec.alusrc = 1'b1;
        dec.auipc = 1'b1; dec.imm = imm_u;
      end
      OP_JAL: begin
        dec.regwr = 1'b1; dec.jal = 1'b1; dec.imm = imm_j;
      end
      OP_JALR: begin
        dec.regwr = 1'b1; dec.alusrc = 1'b1;
        dec.jalr = 1'b1; dec.imm = imm_i; use1 = 1'b1;
      end
      OP_BR: begin
        dec.branch = 1'b1; dec.imm = imm_b;
        use1 = 1'b1; use2 = 1'b1;
      end
      OP_LD: begin
        dec.regwr = 1'b1; dec.memrd = 1'b1;
        dec.alusrc = 1'b1; dec.imm = imm_i; use1 = 1'b1;
      end
      OP_ST: begin
        dec.memwr = 1'b1; dec.alusrc = 1'b1;
        dec.imm = imm_s; use1 = 1'b1; use2 = 1'b1;
      end
      OP_IMM: begin
        dec.regwr = 1'b1; dec.alusrc = 1'b1;
        dec.imm = imm_i; use1 = 1'b1;
      end
      OP_OP: begin
        dec.regwr = 1'b1; use1 = 1'b1; use2 = 1'b1;
      end
      OP_MISC, OP_SYS: dec.imm = imm_i;
      default: dec.illegal = 1'b1;
    endcase
    if (rd == 5'd0) dec.regwr = 1'b0;
  end

  assign haz = iEX_MemRd && iEX_Rd != 5'd0 && !iIF_Stall &&
               !iFlush &&
               ((use1 && iEX_Rd == rs1) || (use2 && iEX_Rd == rs2));

  assign oStall = haz | iStall | ~iEn;

  always_comb begin
    bub    = '0;
    bub.ir = NOP_IR;
  end

  // Flush outranks stall so a redirect is never dropped.
  always_comb begin
    ex_d = ex_q;
    if (iFlush)                ex_d = bub;
    else if (iStall || !iEn)   ex_d = ex_q;
    else if (haz || iIF_Stall) ex_d = bub;
    else                       ex_d = dec;
  end

  always_ff @(posedge iClk or negedge nRst) begin
    if (!nRst) ex_q <= bub;
    else       ex_q <= ex_d;
  end

  assign oValid    = ex_q.valid;
  assign oPC       = ex_q.pc;
  assign oPC4      = ex_q.pc4;
  assign oIR       = ex_q.ir;
  assign oRS1D     = ex_q.rs1d;
  assign oRS2D     = ex_q.rs2d;
  assign oImm      = ex_q.imm;
  assign oRs1      = ex_q.rs1;
  assign oRs2      = ex_q.rs2;
  assign oRd       = ex_q.rd;
  assign oFunct3   = ex_q.funct3;
  assign oFunct7b5 = ex_q.f7b5;
  assign oRegWr    = ex_q.regwr;
  assign oMemRd    = ex_q.memrd;
  assign oMemWr    = ex_q.memwr;
  assign oALUSrc   = ex_q.alusrc;
  assign oBranch   = ex_q.branch;
  assign oJal      = ex_q.jal;
  assign oJalr     = ex_q.jalr;
  assign oLui      = ex_q.lui;
  assign oAuipc    = ex_q.auipc;
  assign oIllegal  = ex_q.illegal;

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: directed literal checks plus randomized
// traffic compared against a behavioural decode model.
module tb_id_stage;

  logic        iClk = 1'b0;
  logic        nRst;
  logic        iEn, iStall, iFlush, iIF_Stall;
  logic [31:0] iPC, iPC4, iIR;
  logic        iWB_En;
  logic [4:0]  iWB_Rd;
  logic [31:0] iWB_Data;
  logic        iEX_MemRd;
  logic [4:0]  iEX_Rd;
  logic        oStall, oValid;
  logic [31:0] oPC, oPC4, oIR, oRS1D, oRS2D, oImm;
  logic [4:0]  oRs1, oRs2, oRd;
  logic [2:0]  oFunct3;
  logic        oFunct7b5, oRegWr, oMemRd, oMemWr, oALUSrc;
  logic        oBranch, oJal, oJalr, oLui, oAuipc, oIllegal;

  id_stage dut (
    .iClk(iClk), .nRst(nRst), .iEn(iEn), .iStall(iStall),
    .iFlush(iFlush), .iIF_Stall(iIF_Stall),
    .iPC(iPC), .iPC4(iPC4), .iIR(iIR),
    .iWB_En(iWB_En), .iWB_Rd(iWB_Rd), .iWB_Data(iWB_Data),
    .iEX_MemRd(iEX_MemRd), .iEX_Rd(iEX_Rd),
    .oStall(oStall), .oValid(oValid),
    .oPC(oPC), .oPC4(oPC4), .oIR(oIR),
    .oRS1D(oRS1D), .oRS2D(oRS2D), .oImm(oImm),
    .oRs1(oRs1), .oRs2(oRs2), .oRd(oRd),
    .oFunct3(oFunct3), .oFunct7b5(oFunct7b5),
    .oRegWr(oRegWr), .oMemRd(oMemRd), .oMemWr(oMemWr),
    .oALUSrc(oALUSrc), .oBranch(oBranch), .oJal(oJal),
    .oJalr(oJalr), .oLui(oLui), .oAuipc(oAuipc),
    .oIllegal(oIllegal)
  );

  always #5 iClk = ~iClk;

  // ctl = {regwr,memrd,memwr,alusrc,branch,jal,jalr,lui,auipc,illegal}
  typedef struct packed {
    logic        valid;
    logic [31:0] pc, pc4, ir, rs1d, rs2d, imm;
    logic [4:0]  rs1, rs2, rd;
    logic [2:0]  f3;
    logic        f7;
    logic [9:0]  ctl;
  } exp_t;

  int   tests = 0;
  int   fails = 0;
  exp_t exp_q;
  logic [31:0] mreg [32];

  function automatic exp_t act();
    exp_t a;
    a.valid = oValid; a.pc = oPC; a.pc4 = oPC4; a.ir = oIR;
    a.rs1d = oRS1D; a.rs2d = oRS2D; a.imm = oImm;
    a.rs1 = oRs1; a.rs2 = oRs2; a.rd = oRd;
    a.f3 = oFunct3; a.f7 = oFunct7b5;
    a.ctl = {oRegWr, oMemRd, oMemWr, oALUSrc, oBranch,
             oJal, oJalr, oLui, oAuipc, oIllegal};
    return a;
  endfunction

  function automatic exp_t bubble();
    exp_t b = '0;
    b.ir = 32'h13;
    return b;
  endfunction

  function automatic logic [31:0] rdreg(input logic [4:0] i);
    if (i == 0) return 32'h0;
    if (iWB_En && iWB_Rd == i) return iWB_Data;
    return mreg[i];
  endfunction

  function automatic exp_t mdec(output logic u1, output logic u2);
    exp_t e = '0;
    byte  fmt;
    logic [31:0] ir = iIR;
    u1 = 0; u2 = 0;
    case (ir[6:0])
      7'h37: begin e.ctl = 10'b1001000100; fmt = "U"; end
      7'h17: begin e.ctl = 10'b1001000010; fmt = "U"; end
      7'h6F: begin e.ctl = 10'b1000010000; fmt = "J"; end
      7'h67: begin e.ctl = 10'b1001001000; fmt = "I"; u1 = 1; end
      7'h63: begin e.ctl = 10'b0000100000; fmt = "B";
                   u1 = 1; u2 = 1; end
      7'h03: begin e.ctl = 10'b1101000000; fmt = "I"; u1 = 1; end
      7'h23: begin e.ctl = 10'b0011000000; fmt = "S";
                   u1 = 1; u2 = 1; end
      7'h13: begin e.ctl = 10'b1001000000; fmt = "I"; u1 = 1; end
      7'h33: begin e.ctl = 10'b1000000000; fmt = "R";
                   u1 = 1; u2 = 1; end
      7'h0F, 7'h73: begin e.ctl = 10'b0; fmt = "I"; end
      default: begin e.ctl = 10'b0000000001; fmt = "R"; end
    endcase
    case (fmt)
      "I": e.imm = {{20{ir[31]}}, ir[31:20]};
      "S": e.imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
      "B": e.imm = {{19{ir[31]}}, ir[31], ir[7], ir[30:25],
                    ir[11:8], 1'b0};
      "U": e.imm = {ir[31:12], 12'h0};
      "J": e.imm = {{11{ir[31]}}, ir[31], ir[19:12], ir[20],
                    ir[30:21], 1'b0};
      default: e.imm = 32'h0;
    endcase
    e.valid = 1; e.pc = iPC; e.pc4 = iPC4; e.ir = ir;
    e.rs1 = ir[19:15]; e.rs2 = ir[24:20]; e.rd = ir[11:7];
    e.rs1d = rdreg(e.rs1); e.rs2d = rdreg(e.rs2);
    e.f3 = ir[14:12]; e.f7 = ir[30];
    if (e.rd == 0) e.ctl[9] = 0;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] a,
                     input logic [31:0] r);
    tests++;
    if (a !== r) begin
      fails++;
      $display("FAIL %s: got %h want %h", nm, a, r);
    end
  endtask

  task automatic chk_all(input string nm);
    tests++;
    if (act() !== exp_q) begin
      fails++;
      $display("FAIL %s: got %h want %h", nm, act(), exp_q);
    end
  endtask

  // Called just after a negedge with inputs already applied.
  task automatic step();
    logic u1, u2, haz;
    exp_t d, nxt;
    #1;
    d   = mdec(u1, u2);
    haz = iEX_MemRd && iEX_Rd != 0 && !iIF_Stall && !iFlush &&
          ((u1 && iEX_Rd == d.rs1) || (u2 && iEX_Rd == d.rs2));
    chk("oStall", {31'b0, oStall},
        {31'b0, haz || iStall || !iEn});
    if (iFlush)                   nxt = bubble();
    else if (iStall || !iEn)      nxt = exp_q;
    else if (haz || iIF_Stall)    nxt = bubble();
    else                          nxt = d;
    @(posedge iClk);
    if (iWB_En && iWB_Rd != 0) mreg[iWB_Rd] = iWB_Data;
    exp_q = nxt;
    #1;
    chk_all("outputs");
    @(negedge iClk);
  endtask

  task automatic idle();
    iEn = 1; iStall = 0; iFlush = 0; iIF_Stall = 0;
    iWB_En = 0; iWB_Rd = 0; iWB_Data = 0;
    iEX_MemRd = 0; iEX_Rd = 0;
  endtask

  task automatic mreset();
    for (int i = 0; i < 32; i++) mreg[i] = 0;
    exp_q = bubble();
  endtask

  function automatic logic [31:0] rand_ir();
    logic [6:0] ops [12];
    logic [31:0] r;
    ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03,
            7'h23, 7'h13, 7'h33, 7'h0F, 7'h73, 7'h00};
    r = $urandom;
    if ($urandom_range(0, 9) != 0)
      r[6:0] = ops[$urandom_range(0, 11)];
    return r;
  endfunction

  initial begin
    nRst = 0; idle();
    iPC = 0; iPC4 = 0; iIR = 0;
    mreset();
    repeat (2) @(negedge iClk);
    chk("rst_oValid", {31'b0, oValid}, 32'h0);
    chk("rst_oIR", oIR, 32'h13);
    chk_all("rst_all");
    nRst = 1;

    iPC = 32'h100; iPC4 = 32'h104; iIR = 32'h0050_0093;
    step();
    chk("addi_valid", {31'b0, oValid}, 32'h1);
    chk("addi_regwr", {31'b0, oRegWr}, 32'h1);
    chk("addi_alusrc", {31'b0, oALUSrc}, 32'h1);
    chk("addi_rd", {27'b0, oRd}, 32'h1);
    chk("addi_imm", oImm, 32'h5);
    chk("addi_rs1d", oRS1D, 32'h0);

    iWB_En = 1; iWB_Rd = 3; iWB_Data = 32'hDEAD_BEEF;
    iIR = 32'h0001_8133;
    step();
    chk("bypass_rs1d", oRS1D, 32'hDEAD_BEEF);

    iWB_Rd = 0; iWB_Data = 32'h1234; iIR = 32'h0000_0133;
    step();
    iWB_En = 0;
    step();
    chk("x0_rs1d", oRS1D, 32'h0);
    chk("x0_rs2d", oRS2D, 32'h0);

    iEX_MemRd = 1; iEX_Rd = 5; iIR = 32'h0052_8333;
    #1 chk("luse_stall", {31'b0, oStall}, 32'h1);
    step();
    chk("luse_bubble", {31'b0, oValid}, 32'h0);
    chk("luse_nop", oIR, 32'h13);
    iEX_MemRd = 0;
    step();
    chk("luse_valid", {31'b0, oValid}, 32'h1);
    chk("luse_rd", {27'b0, oRd}, 32'h6);

    iIR = 32'hFE00_0EE3;
    step();
    chk("beq_branch", {31'b0, oBranch}, 32'h1);
    chk("beq_imm", oImm, 32'hFFFF_FFFC);

    iEn = 0; iIR = 32'h0050_0093;
    step();
    chk("en_hold_ir", oIR, 32'hFE00_0EE3);
    iEn = 1;

    iFlush = 1; iStall = 1; iIR = 32'h0050_0093;
    step();
    chk("flush_valid", {31'b0, oValid}, 32'h0);
    chk("flush_ir", oIR, 32'h13);
    chk("flush_regwr", {31'b0, oRegWr}, 32'h0);
    iFlush = 0; iStall = 0;

    iIR = 32'hFFFF_FFFF;
    step();
    chk("ill_illegal", {31'b0, oIllegal}, 32'h1);
    chk("ill_regwr", {31'b0, oRegWr}, 32'h0);
    chk("ill_valid", {31'b0, oValid}, 32'h1);

    iIF_Stall = 1;
    step();
    chk("ifstall_valid", {31'b0, oValid}, 32'h0);
    iIF_Stall = 0;

    for (int n = 0; n < 600; n++) begin
      iEn       = ($urandom_range(0, 9) != 0);
      iStall    = ($urandom_range(0, 6) == 0);
      iFlush    = ($urandom_range(0, 9) == 0);
      iIF_Stall = ($urandom_range(0, 6) == 0);
      iPC       = $urandom & 32'hFFFF_FFFC;
      iPC4      = iPC + 4;
      iIR       = rand_ir();
      iWB_En    = $urandom_range(0, 1);
      iWB_Rd    = 5'($urandom_range(0, 31));
      iWB_Data  = $urandom;
      iEX_MemRd = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 2))
        0: iEX_Rd = iIR[19:15];
        1: iEX_Rd = iIR[24:20];
        default: iEX_Rd = 5'($urandom_range(0, 31));
      endcase
      if (n == 300) begin
        iStall = 1;
        #2 nRst = 0;
        #1 chk("midrst_valid", {31'b0, oValid}, 32'h0);
        chk("midrst_ir", oIR, 32'h13);
        mreset();
        chk_all("midrst_all");
        @(negedge iClk);
        nRst = 1; idle(); iIF_Stall = 1;
      end
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
